// File: rtl/can_rx_frame_reader.sv
// can_rx_frame_reader: drains SJA1000 PeliCAN RX buffer frames on interrupt and presents them on a valid/ready port
module can_rx_frame_reader #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        res_n,
  input  logic        enable_i,
  input  logic        irq_n_i,
  output logic        reg_re_o,
  output logic [7:0]  reg_addr_read_o,
  input  logic [7:0]  reg_data_i,
  output logic        reg_we_o,
  output logic [7:0]  reg_addr_write_o,
  output logic [7:0]  reg_data_o,
  output logic        frame_valid_o,
  input  logic        frame_ready_i,
  output logic        frame_ide_o,
  output logic        frame_rtr_o,
  output logic [3:0]  frame_dlc_o,
  output logic [28:0] frame_id_o,
  output logic [63:0] frame_data_o,
  output logic [15:0] frames_cnt_o,
  output logic [7:0]  overrun_cnt_o
);
  typedef enum logic [3:0] {IDLE, RD_IR, RD_INFO, RD_ID, RD_DATA, RELEASE, OUTPUT, RD_SR, CLR_DO} state_t;
  localparam logic [1:0] LAT = 2'(READ_LATENCY);
  state_t state, nxt;
  logic [1:0] cnt;
  logic [2:0] idx;
  logic [31:0] id_raw;
  logic ri;
  logic rd;
  logic done;
  logic [2:0] nid_m1;
  logic [3:0] ndata;
  always_comb begin
    rd = state inside {RD_IR, RD_INFO, RD_ID, RD_DATA, RD_SR};
    done = rd && cnt == LAT;
    nid_m1 = frame_ide_o ? 3'd3 : 3'd1;
    ndata = frame_rtr_o ? 4'd0 : frame_dlc_o > 4'd8 ? 4'd8 : frame_dlc_o;
    reg_re_o = rd && cnt == 2'd0;
    reg_we_o = state == CLR_DO || state == RELEASE;
    reg_addr_write_o = {7'd0, reg_we_o};
    reg_data_o = state == CLR_DO ? 8'h08 : state == RELEASE ? 8'h04 : 8'h00;
    reg_addr_read_o = state == RD_IR ? 8'd3 :
                      state == RD_SR ? 8'd2 :
                      state == RD_INFO ? 8'd16 :
                      state == RD_ID ? 8'd17 + 8'(idx) :
                      state == RD_DATA ? 8'd18 + 8'(nid_m1) + 8'(idx) : 8'd0;
    frame_valid_o = state == OUTPUT;
    frame_id_o = 29'(frame_ide_o ? id_raw >> 3 : {16'd0, id_raw[15:0]} >> 5);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = enable_i && !irq_n_i ? RD_IR : IDLE;
      RD_IR:   if (done) nxt = reg_data_i[3] ? CLR_DO : reg_data_i[0] ? RD_INFO : IDLE;
      CLR_DO:  nxt = ri ? RD_INFO : IDLE;
      RD_INFO: if (done) nxt = RD_ID;
      RD_ID:   if (done && idx == nid_m1) nxt = ndata == 4'd0 ? RELEASE : RD_DATA;
      RD_DATA: if (done && {1'b0, idx} == ndata - 4'd1) nxt = RELEASE;
      RELEASE: nxt = OUTPUT;
      OUTPUT:  if (frame_ready_i) nxt = RD_SR;
      RD_SR:   if (done) nxt = reg_data_i[0] ? RD_INFO : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge res_n) begin
    if (!res_n) begin
      state <= IDLE;
      cnt <= 2'd0;
      idx <= 3'd0;
      ri <= 1'b0;
      id_raw <= 32'd0;
      frame_ide_o <= 1'b0;
      frame_rtr_o <= 1'b0;
      frame_dlc_o <= 4'd0;
      frame_data_o <= 64'd0;
      frames_cnt_o <= 16'd0;
      overrun_cnt_o <= 8'd0;
    end else begin
      state <= nxt;
      cnt <= rd && !done ? cnt + 2'd1 : 2'd0;
      idx <= nxt != state ? 3'd0 : done ? idx + 3'd1 : idx;
      if (nxt == RD_INFO && state != RD_INFO) begin
        id_raw <= 32'd0;
        frame_data_o <= 64'd0;
      end
      if (done && state == RD_IR) begin
        ri <= reg_data_i[0];
        if (reg_data_i[3] && overrun_cnt_o != 8'hFF) overrun_cnt_o <= overrun_cnt_o + 8'd1;
      end
      if (done && state == RD_INFO) {frame_ide_o, frame_rtr_o, frame_dlc_o} <= {reg_data_i[7:6], reg_data_i[3:0]};
      if (done && state == RD_ID) id_raw <= {id_raw[23:0], reg_data_i};
      if (done && state == RD_DATA) frame_data_o <= frame_data_o | ({reg_data_i, 56'd0} >> {idx, 3'b000});
      if (frame_valid_o && frame_ready_i) frames_cnt_o <= frames_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_can_rx_frame_reader.sv
// tb_can_rx_frame_reader: directed bench with a register-file controller model and a frame/bus-sequence scoreboard
module tb_can_rx_frame_reader;
  logic clk_i = 1'b0;
  logic res_n = 1'b0;
  logic enable_i = 1'b0;
  logic irq_n_i = 1'b1;
  logic reg_re_o, reg_we_o, frame_valid_o, frame_ide_o, frame_rtr_o;
  logic frame_ready_i = 1'b1;
  logic [7:0] reg_addr_read_o, reg_addr_write_o, reg_data_o, overrun_cnt_o;
  logic [7:0] reg_data_i = 8'd0;
  logic [3:0] frame_dlc_o;
  logic [28:0] frame_id_o;
  logic [63:0] frame_data_o;
  logic [15:0] frames_cnt_o;

  typedef struct packed {logic ide; logic rtr; logic [3:0] dlc; logic [28:0] id; logic [63:0] data;} frame_t;
  typedef struct packed {logic w; logic [7:0] a; logic [7:0] d;} acc_t;

  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, strobes = 0, data_reads = 0, t_re = 0, t_valid = 0;
  logic v_prev = 1'b0;
  logic [7:0] ir = 8'd0;
  frame_t buf_q[$];
  frame_t pend[$];
  frame_t exp_fr[$];
  acc_t exp_bus[$];
  frame_t last_fr, mf;
  acc_t me;

  can_rx_frame_reader #(.READ_LATENCY(1)) dut (
    .clk_i(clk_i), .res_n(res_n), .enable_i(enable_i), .irq_n_i(irq_n_i),
    .reg_re_o(reg_re_o), .reg_addr_read_o(reg_addr_read_o), .reg_data_i(reg_data_i),
    .reg_we_o(reg_we_o), .reg_addr_write_o(reg_addr_write_o), .reg_data_o(reg_data_o),
    .frame_valid_o(frame_valid_o), .frame_ready_i(frame_ready_i), .frame_ide_o(frame_ide_o),
    .frame_rtr_o(frame_rtr_o), .frame_dlc_o(frame_dlc_o), .frame_id_o(frame_id_o),
    .frame_data_o(frame_data_o), .frames_cnt_o(frames_cnt_o), .overrun_cnt_o(overrun_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_byte(input logic [7:0] a);
    frame_t f;
    int nid, k;
    if (a == 8'd3) return ir;
    if (a == 8'd2) return {7'd0, buf_q.size() != 0};
    if (buf_q.size() == 0 || a < 8'd16 || a > 8'd28) return 8'hEE;
    f = buf_q[0];
    nid = f.ide ? 4 : 2;
    if (a == 8'd16) return {f.ide, f.rtr, 2'b00, f.dlc};
    k = int'(a) - 17;
    if (k < nid) return f.ide ? 8'({f.id, 3'b000} >> (8 * (3 - k))) : 8'({f.id[10:0], 5'b00000} >> (8 * (1 - k)));
    k -= nid;
    return k < 8 ? 8'(f.data >> (8 * (7 - k))) : 8'hEE;
  endfunction

  initial begin
    logic re_s, we_s;
    logic [7:0] ra, wa, wd;
    forever begin
      @(posedge clk_i);
      re_s = reg_re_o; we_s = reg_we_o;
      ra = reg_addr_read_o; wa = reg_addr_write_o; wd = reg_data_o;
      #1;
      if (re_s) begin
        reg_data_i = reg_byte(ra);
        if (ra == 8'd3) ir = 8'd0;
      end
      if (we_s && wa == 8'd1 && wd[2] && buf_q.size() != 0) void'(buf_q.pop_front());
      irq_n_i = ir == 8'd0;
    end
  end

  always @(negedge clk_i) begin
    if (res_n) begin
      chk("frames_cnt", 64'(frames_cnt_o), 64'(acc_cnt));
      chk("re_we_exclusive", 64'(reg_re_o & reg_we_o), 64'd0);
      if (reg_re_o || reg_we_o) begin
        strobes++;
        if (reg_re_o && reg_addr_read_o == 8'd3) t_re = cyc;
        if (reg_re_o && reg_addr_read_o >= 8'd19) data_reads++;
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected: re=%0d raddr=%0d we=%0d waddr=%0d, expected no strobe", reg_re_o, reg_addr_read_o, reg_we_o, reg_addr_write_o);
        end else begin
          me = exp_bus.pop_front();
          chk("bus_dir", 64'(reg_we_o), 64'(me.w));
          chk("bus_addr", 64'(reg_we_o ? reg_addr_write_o : reg_addr_read_o), 64'(me.a));
          if (me.w) chk("bus_wdata", 64'(reg_data_o), 64'(me.d));
        end
      end
      if (frame_valid_o && !v_prev) t_valid = cyc;
      if (frame_valid_o && frame_ready_i) begin
        if (exp_fr.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: got id 0x%0h, expected no frame", frame_id_o);
        end else begin
          mf = exp_fr.pop_front();
          chk("frame_hdr", 64'({frame_ide_o, frame_rtr_o, frame_dlc_o}), 64'({mf.ide, mf.rtr, mf.dlc}));
          chk("frame_id", 64'(frame_id_o), 64'(mf.id));
          chk("frame_data", frame_data_o, mf.data);
        end
        last_fr = {frame_ide_o, frame_rtr_o, frame_dlc_o, frame_id_o, frame_data_o};
        acc_cnt++;
      end
    end
    v_prev = frame_valid_o;
  end

  task automatic push_frame_exp(input frame_t f);
    int nid = f.ide ? 4 : 2;
    int n = f.rtr ? 0 : (f.dlc > 4'd8 ? 8 : int'(f.dlc));
    frame_t e = f;
    exp_bus.push_back('{1'b0, 8'd16, 8'd0});
    for (int i = 0; i < nid + n; i++) exp_bus.push_back('{1'b0, 8'(17 + i), 8'd0});
    exp_bus.push_back('{1'b1, 8'd1, 8'h04});
    exp_bus.push_back('{1'b0, 8'd2, 8'd0});
    e.data = n == 0 ? 64'd0 : f.data & ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * n));
    exp_fr.push_back(e);
  endtask

  task automatic svc(input logic [7:0] irv);
    exp_bus.push_back('{1'b0, 8'd3, 8'd0});
    if (irv[3]) exp_bus.push_back('{1'b1, 8'd1, 8'h08});
    foreach (pend[i]) begin
      buf_q.push_back(pend[i]);
      if (irv[0]) push_frame_exp(pend[i]);
    end
    pend.delete();
    ir = irv;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk_i);
    while ((exp_bus.size() != 0 || frame_valid_o) && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    chk("service_timeout", 64'(n >= 400), 64'd0);
    repeat (4) @(negedge clk_i);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!frame_valid_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("valid_timeout", 64'(n >= 300), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({reg_re_o, reg_we_o, frame_valid_o, frame_ide_o, frame_rtr_o, frame_dlc_o, reg_addr_read_o,
                            reg_addr_write_o, reg_data_o, frames_cnt_o, overrun_cnt_o}), 64'd0);
    chk({tag, "_id"}, 64'(frame_id_o), 64'd0);
    chk({tag, "_data"}, frame_data_o, 64'd0);
  endtask

  initial begin
    int s0;
    #12;
    chk_zero("reset");
    @(negedge clk_i);
    res_n = 1'b1;
    enable_i = 1'b1;
    repeat (2) @(negedge clk_i);
    pend.push_back('{1'b0, 1'b0, 4'd2, 29'h123, 64'hA55A_1122_3344_5566});
    svc(8'h01);
    wait_done();
    chk("std_id", 64'(last_fr.id), 64'h123);
    chk("std_ide", 64'(last_fr.ide), 64'd0);
    chk("std_data", last_fr.data, 64'hA55A_0000_0000_0000);
    chk("std_latency", 64'(t_valid - t_re), 64'd13);
    pend.push_back('{1'b1, 1'b1, 4'd8, 29'h1ABCDEF1, 64'hDEAD_BEEF_CAFE_F00D});
    svc(8'h01);
    wait_done();
    chk("rtr_hdr", 64'({last_fr.ide, last_fr.rtr, last_fr.dlc}), 64'h38);
    chk("rtr_id", 64'(last_fr.id), 64'h1ABCDEF1);
    chk("rtr_data", last_fr.data, 64'd0);
    data_reads = 0;
    pend.push_back('{1'b0, 1'b0, 4'hF, 29'h7FF, 64'h0102_0304_0506_0708});
    svc(8'h01);
    wait_done();
    chk("dlcf_reads", 64'(data_reads), 64'd8);
    chk("dlcf_dlc", 64'(last_fr.dlc), 64'hF);
    chk("dlcf_data", last_fr.data, 64'h0102_0304_0506_0708);
    chk("dlcf_latency", 64'(t_valid - t_re), 64'd25);
    pend.push_back('{1'b1, 1'b0, 4'd8, 29'h15555555, 64'h0011_2233_4455_6677});
    svc(8'h01);
    wait_done();
    chk("ext8_latency", 64'(t_valid - t_re), 64'd29);
    chk("ext8_id", 64'(last_fr.id), 64'h15555555);
    frame_ready_i = 1'b0;
    pend.push_back('{1'b0, 1'b0, 4'd3, 29'h5A5, 64'h1234_5600_0000_0000});
    svc(8'h01);
    wait_valid();
    s0 = strobes;
    repeat (50) begin
      @(negedge clk_i);
      chk("bp_valid", 64'(frame_valid_o), 64'd1);
      chk("bp_id", 64'(frame_id_o), 64'(exp_fr[0].id));
      chk("bp_data", frame_data_o, exp_fr[0].data);
    end
    chk("bp_no_strobes", 64'(strobes - s0), 64'd0);
    @(posedge clk_i);
    #1 frame_ready_i = 1'b1;
    @(posedge clk_i);
    #1 chk("bp_cnt", 64'(frames_cnt_o), 64'd5);
    wait_done();
    pend.push_back('{1'b0, 1'b0, 4'd1, 29'h001, 64'hFF00_0000_0000_0000});
    pend.push_back('{1'b1, 1'b0, 4'd3, 29'h0000_0000, 64'hABCD_EF99_9999_9999});
    svc(8'h01);
    wait_done();
    chk("two_cnt", 64'(frames_cnt_o), 64'd7);
    pend.push_back('{1'b0, 1'b0, 4'd1, 29'h3C3, 64'h7700_0000_0000_0000});
    svc(8'h09);
    wait_done();
    chk("ovr_cnt1", 64'(overrun_cnt_o), 64'd1);
    chk("ovr_frames", 64'(frames_cnt_o), 64'd8);
    svc(8'h08);
    wait_done();
    chk("ovr_cnt2", 64'(overrun_cnt_o), 64'd2);
    enable_i = 1'b0;
    pend.push_back('{1'b0, 1'b0, 4'd0, 29'h0AA, 64'd0});
    svc(8'h01);
    s0 = strobes;
    repeat (20) @(negedge clk_i);
    chk("dis_no_strobes", 64'(strobes - s0), 64'd0);
    enable_i = 1'b1;
    wait_done();
    chk("en_cnt", 64'(frames_cnt_o), 64'd9);
    pend.push_back('{1'b1, 1'b0, 4'd8, 29'h0F0F0F0F, 64'h1111_2222_3333_4444});
    svc(8'h01);
    s0 = 0;
    while (!(reg_re_o && reg_addr_read_o >= 8'd23) && s0 < 300) begin
      @(negedge clk_i);
      s0++;
    end
    chk("rst_reach_data", 64'(s0 >= 300), 64'd0);
    #2 res_n = 1'b0;
    #1 chk_zero("rst_mid");
    exp_bus.delete();
    exp_fr.delete();
    acc_cnt = 0;
    repeat (3) begin
      @(negedge clk_i);
      chk("rst_quiet", 64'(reg_re_o | reg_we_o), 64'd0);
    end
    res_n = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("rst_buffer_kept", 64'(buf_q.size()), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 200000 time units");
    $fatal(1, "watchdog");
  end
endmodule
